// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM block family: common word width and the
// breathing sequencer state encoding.
package pwm_pkg;

    localparam int PWM_W = 27;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RAMP_UP   = 3'd1,
        HOLD_HI   = 3'd2,
        RAMP_DOWN = 3'd3,
        HOLD_LO   = 3'd4
    } breath_state_t;

endpackage

// File: rtl/pwm_breath_seq_if.sv
// Control/status bundle between a breathing-envelope sequencer and its controller.
// The sequencer takes the slave view; whoever configures it takes the master view.
interface pwm_breath_seq_if
    import pwm_pkg::*;
#(
    parameter int W     = PWM_W,
    parameter int DIV_W = 20,
    parameter int CNT_W = 8
);
    logic             start;
    logic             stop;
    logic [W-1:0]     cfg_period;
    logic [W-1:0]     cfg_step;
    logic [DIV_W-1:0] cfg_div;
    logic [CNT_W-1:0] cfg_hold;
    logic [CNT_W-1:0] cfg_reps;
    logic [W-1:0]     pwm_period;
    logic [W-1:0]     pwm_duty;
    logic             busy;
    logic             done;

    modport master (
        output start, stop, cfg_period, cfg_step, cfg_div, cfg_hold, cfg_reps,
        input  pwm_period, pwm_duty, busy, done
    );

    modport slave (
        input  start, stop, cfg_period, cfg_step, cfg_div, cfg_hold, cfg_reps,
        output pwm_period, pwm_duty, busy, done
    );
endinterface

// File: rtl/pwm_tick_div.sv
// Programmable prescaler: counts 0..div while enabled and flags the wrap cycle.
// A clear restarts the count from zero so the first tick lands div+1 clocks later.
module pwm_tick_div #(
    parameter int DIV_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);
    logic [DIV_W-1:0] cnt;

    assign tick = en && (cnt == div);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + DIV_W'(1);
        end
    end
endmodule

// File: rtl/pwm_breath_seq.sv
// Breathing duty-cycle sequencer: ramps a PWM duty word up to the period, holds,
// ramps back to zero, holds, and repeats for a configured number of cycles.
module pwm_breath_seq
    import pwm_pkg::*;
#(
    parameter int W     = PWM_W,
    parameter int DIV_W = 20,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    pwm_breath_seq_if.slave  bus
);
    breath_state_t    state, state_nx;
    logic [W-1:0]     duty, duty_nx;
    logic [W-1:0]     period, period_nx;
    logic [W-1:0]     step, step_nx;
    logic [DIV_W-1:0] div, div_nx;
    logic [CNT_W-1:0] hold, hold_nx;
    logic [CNT_W-1:0] reps, reps_nx;
    logic [CNT_W-1:0] hold_cnt, hold_cnt_nx;
    logic [CNT_W-1:0] rep_cnt, rep_cnt_nx;
    logic             busy, busy_nx;
    logic             done, done_nx;
    logic             accept;
    logic             tick;
    logic [W-1:0]     up_val, down_val;
    logic [CNT_W:0]   hold_inc;
    logic             hold_last;
    logic [CNT_W-1:0] rep_inc;
    logic             reps_done;

    // Widened add so a large step near the ceiling saturates instead of wrapping.
    function automatic logic [W-1:0] sat_add(input logic [W-1:0] a,
                                             input logic [W-1:0] b,
                                             input logic [W-1:0] ceil);
        logic [W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, ceil}) ? ceil : sum[W-1:0];
    endfunction

    function automatic logic [W-1:0] floor_sub(input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        return (a > b) ? a - b : '0;
    endfunction

    pwm_tick_div #(.DIV_W(DIV_W)) u_tick_div (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (accept),
        .en    (busy),
        .div   (div),
        .tick  (tick)
    );

    assign up_val    = sat_add(duty, step, period);
    assign down_val  = floor_sub(duty, step);
    // A hold of zero behaves like one: the state is left on its first tick.
    assign hold_inc  = {1'b0, hold_cnt} + {{CNT_W{1'b0}}, 1'b1};
    assign hold_last = (hold_inc >= {1'b0, hold});
    assign rep_inc   = rep_cnt + CNT_W'(1);
    assign reps_done = (reps != '0) && (rep_inc == reps);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            duty     <= '0;
            period   <= '0;
            step     <= '0;
            div      <= '0;
            hold     <= '0;
            reps     <= '0;
            hold_cnt <= '0;
            rep_cnt  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nx;
            duty     <= duty_nx;
            period   <= period_nx;
            step     <= step_nx;
            div      <= div_nx;
            hold     <= hold_nx;
            reps     <= reps_nx;
            hold_cnt <= hold_cnt_nx;
            rep_cnt  <= rep_cnt_nx;
            busy     <= busy_nx;
            done     <= done_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        duty_nx     = duty;
        period_nx   = period;
        step_nx     = step;
        div_nx      = div;
        hold_nx     = hold;
        reps_nx     = reps;
        hold_cnt_nx = hold_cnt;
        rep_cnt_nx  = rep_cnt;
        busy_nx     = busy;
        done_nx     = 1'b0;
        accept      = 1'b0;

        case (state)
            IDLE: begin
                if (bus.start && !bus.stop) begin
                    accept      = 1'b1;
                    state_nx    = RAMP_UP;
                    duty_nx     = '0;
                    period_nx   = bus.cfg_period;
                    step_nx     = (bus.cfg_step == '0) ? W'(1) : bus.cfg_step;
                    div_nx      = bus.cfg_div;
                    hold_nx     = bus.cfg_hold;
                    reps_nx     = bus.cfg_reps;
                    hold_cnt_nx = '0;
                    rep_cnt_nx  = '0;
                    busy_nx     = 1'b1;
                end
            end
            RAMP_UP: begin
                if (tick) begin
                    duty_nx = up_val;
                    if (up_val == period) begin
                        state_nx    = HOLD_HI;
                        hold_cnt_nx = '0;
                    end
                end
            end
            HOLD_HI: begin
                if (tick) begin
                    if (hold_last) state_nx = RAMP_DOWN;
                    else           hold_cnt_nx = hold_inc[CNT_W-1:0];
                end
            end
            RAMP_DOWN: begin
                if (tick) begin
                    duty_nx = down_val;
                    if (down_val == '0) begin
                        state_nx    = HOLD_LO;
                        hold_cnt_nx = '0;
                    end
                end
            end
            HOLD_LO: begin
                if (tick) begin
                    if (hold_last) begin
                        rep_cnt_nx = rep_inc;
                        if (reps_done) begin
                            state_nx = IDLE;
                            busy_nx  = 1'b0;
                            done_nx  = 1'b1;
                        end else begin
                            state_nx = RAMP_UP;
                        end
                    end else begin
                        hold_cnt_nx = hold_inc[CNT_W-1:0];
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                busy_nx  = 1'b0;
            end
        endcase

        // Abort overrides whatever the active state decided this cycle.
        if (state != IDLE && bus.stop) begin
            state_nx = IDLE;
            duty_nx  = '0;
            busy_nx  = 1'b0;
            done_nx  = 1'b1;
        end
    end

    assign bus.pwm_duty   = duty;
    assign bus.pwm_period = period;
    assign bus.busy       = busy;
    assign bus.done       = done;
endmodule

// File: tb/tb_pwm_breath_seq.sv
// Self-checking bench for pwm_breath_seq: table vectors, hand-written corner
// sequences and randomized configurations against an envelope model.
module tb_pwm_breath_seq;
    localparam int W     = 27;
    localparam int DIV_W = 20;
    localparam int CNT_W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    pwm_breath_seq_if #(.W(W), .DIV_W(DIV_W), .CNT_W(CNT_W)) bus ();

    pwm_breath_seq #(.W(W), .DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int period;
        int step;
        int div;
        int hold;
        int reps;
        int n;
        int seq[16];
    } vec_t;

    vec_t vecs[5];
    int   total = 0;
    int   bad   = 0;
    int   model_q[$];

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int e_duty, input bit e_busy,
                       input bit e_done, input int e_period);
        total++;
        if (bus.pwm_duty !== W'(e_duty) || bus.busy !== e_busy ||
            bus.done !== e_done || bus.pwm_period !== W'(e_period)) begin
            bad++;
            $display("FAIL %s: got duty=%0d busy=%0b done=%0b period=%0d, want duty=%0d busy=%0b done=%0b period=%0d",
                     name, bus.pwm_duty, bus.busy, bus.done, bus.pwm_period,
                     e_duty, e_busy, e_done, e_period);
        end
    endtask

    task automatic drive_cfg(input int p, input int s, input int dv, input int h, input int r);
        bus.cfg_period = W'(p);
        bus.cfg_step   = W'(s);
        bus.cfg_div    = DIV_W'(dv);
        bus.cfg_hold   = CNT_W'(h);
        bus.cfg_reps   = CNT_W'(r);
    endtask

    // Envelope as a list of duty values, one per step tick, from the ramp/hold rules.
    function automatic void build_model(input int p, input int s, input int h, input int r);
        int d;
        int st;
        int hl;
        model_q.delete();
        st = (s == 0) ? 1 : s;
        hl = (h == 0) ? 1 : h;
        for (int c = 0; c < r; c++) begin
            d = 0;
            do begin
                d = (d + st > p) ? p : d + st;
                model_q.push_back(d);
            end while (d != p);
            repeat (hl) model_q.push_back(p);
            do begin
                d = (d > st) ? d - st : 0;
                model_q.push_back(d);
            end while (d != 0);
            repeat (hl) model_q.push_back(0);
        end
    endfunction

    // Start a run and check every clock until the done pulse has cleared.
    task automatic run_seq(input string tag, input int p, input int s, input int dv,
                           input int h, input int r, input bit scramble);
        int total_clk;
        int k;
        int ed;
        drive_cfg(p, s, dv, h, r);
        bus.start = 1'b1;
        step_clk();
        bus.start = 1'b0;
        chk({tag, "/start"}, 0, 1'b1, 1'b0, p);
        total_clk = model_q.size() * (dv + 1);
        for (int c = 1; c <= total_clk; c++) begin
            if (scramble)
                drive_cfg($urandom_range(0, 300), $urandom_range(0, 300),
                          $urandom_range(0, 7), $urandom_range(0, 9), $urandom_range(0, 3));
            step_clk();
            k  = c / (dv + 1);
            ed = (k == 0) ? 0 : model_q[k-1];
            chk(tag, ed, c < total_clk, c == total_clk, p);
        end
        step_clk();
        chk({tag, "/after"}, 0, 1'b0, 1'b0, p);
    endtask

    initial begin
        int ramp[7];
        int p;
        int s;
        int dv;
        int h;
        int r;

        vecs[0] = '{period:100, step:25, div:0, hold:2, reps:1, n:12,
                    seq:'{25, 50, 75, 100, 100, 100, 75, 50, 25, 0, 0, 0, 0, 0, 0, 0}};
        vecs[1] = '{period:100, step:30, div:0, hold:0, reps:1, n:10,
                    seq:'{30, 60, 90, 100, 100, 70, 40, 10, 0, 0, 0, 0, 0, 0, 0, 0}};
        vecs[2] = '{period:0, step:5, div:0, hold:0, reps:1, n:4,
                    seq:'{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}};
        vecs[3] = '{period:3, step:0, div:0, hold:1, reps:1, n:8,
                    seq:'{1, 2, 3, 3, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}};
        vecs[4] = '{period:40, step:20, div:3, hold:1, reps:2, n:12,
                    seq:'{20, 40, 40, 20, 0, 0, 20, 40, 40, 20, 0, 0, 0, 0, 0, 0}};

        bus.start = 1'b0;
        bus.stop  = 1'b0;
        drive_cfg(0, 0, 0, 0, 0);
        rst_n = 1'b0;
        step_clk();
        step_clk();
        chk("reset", 0, 1'b0, 1'b0, 0);
        rst_n = 1'b1;
        step_clk();
        chk("reset_release", 0, 1'b0, 1'b0, 0);

        // Stop alone, then stop together with start, while idle.
        bus.stop = 1'b1;
        step_clk();
        chk("stop_idle", 0, 1'b0, 1'b0, 0);
        drive_cfg(100, 25, 0, 2, 1);
        bus.start = 1'b1;
        step_clk();
        step_clk();
        chk("start_stop_idle", 0, 1'b0, 1'b0, 0);
        bus.start = 1'b0;
        bus.stop  = 1'b0;

        for (int v = 0; v < 5; v++) begin
            model_q.delete();
            for (int i = 0; i < vecs[v].n; i++) model_q.push_back(vecs[v].seq[i]);
            run_seq($sformatf("vec%0d", v), vecs[v].period, vecs[v].step, vecs[v].div,
                    vecs[v].hold, vecs[v].reps, v == 4);
        end

        for (int t = 0; t < 10; t++) begin
            p  = $urandom_range(0, 120);
            s  = $urandom_range(0, 40);
            dv = $urandom_range(0, 3);
            h  = $urandom_range(0, 3);
            r  = $urandom_range(1, 2);
            build_model(p, s, h, r);
            run_seq($sformatf("rand%0d", t), p, s, dv, h, r, 1'b1);
        end

        // Endless run aborted mid ramp-down at duty 50.
        ramp = '{25, 50, 75, 100, 100, 75, 50};
        drive_cfg(100, 25, 0, 0, 0);
        bus.start = 1'b1;
        step_clk();
        bus.start = 1'b0;
        chk("stop/start", 0, 1'b1, 1'b0, 100);
        for (int i = 0; i < 7; i++) begin
            step_clk();
            chk($sformatf("stop/ramp%0d", i), ramp[i], 1'b1, 1'b0, 100);
        end
        bus.stop = 1'b1;
        step_clk();
        chk("stop/abort", 0, 1'b0, 1'b1, 100);
        step_clk();
        chk("stop/idle", 0, 1'b0, 1'b0, 100);
        bus.stop = 1'b0;

        // Asynchronous reset while holding high.
        drive_cfg(100, 50, 0, 3, 1);
        bus.start = 1'b1;
        step_clk();
        bus.start = 1'b0;
        repeat (3) step_clk();
        chk("rst/hold_hi", 100, 1'b1, 1'b0, 100);
        rst_n = 1'b0;
        #1;
        chk("rst/async", 0, 1'b0, 1'b0, 0);
        step_clk();
        rst_n = 1'b1;
        step_clk();
        step_clk();
        chk("rst/no_done", 0, 1'b0, 1'b0, 0);

        // Start held through completion restarts and re-latches the config.
        drive_cfg(10, 10, 0, 0, 1);
        bus.start = 1'b1;
        step_clk();
        chk("held/start", 0, 1'b1, 1'b0, 10);
        ramp = '{10, 10, 0, 0, 0, 0, 0};
        for (int i = 0; i < 3; i++) begin
            step_clk();
            chk($sformatf("held/tick%0d", i), ramp[i], 1'b1, 1'b0, 10);
        end
        step_clk();
        chk("held/done", 0, 1'b0, 1'b1, 10);
        drive_cfg(20, 10, 0, 0, 1);
        step_clk();
        chk("held/relatch", 0, 1'b1, 1'b0, 20);
        bus.start = 1'b0;
        bus.stop  = 1'b1;
        step_clk();
        chk("held/abort", 0, 1'b0, 1'b1, 20);
        bus.stop = 1'b0;
        step_clk();
        chk("held/idle", 0, 1'b0, 1'b0, 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
